// File: rtl/aes_key_expander.sv
// AES-128 key expander: one round key per clock into an 11-entry bank,
// with a registered read port used by the decryption datapath.

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as a^254 (maps 0 to 0), then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    assign o_byte = sbox(i_byte);

endmodule

module aes_key_expander #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    input  logic [3:0]    round_idx,
    output logic [KW-1:0] round_key,
    output logic          busy,
    output logic          key_ready
);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_load;
    logic          w_step;
    logic          w_last;

    logic [KW-1:0] r_bank [0:NR];
    logic [KW-1:0] r_key;
    logic [3:0]    r_cnt;
    logic [7:0]    r_rcon;
    logic          r_busy;
    logic          r_key_ready;
    logic [KW-1:0] r_round_key;

    logic [31:0]   w_rot;
    logic [31:0]   w_sub;
    logic [31:0]   w_temp;
    logic [31:0]   w_w0;
    logic [31:0]   w_w1;
    logic [31:0]   w_w2;
    logic [31:0]   w_w3;
    logic [KW-1:0] w_next_key;
    logic [7:0]    w_rcon_next;

    assign w_rot = {r_key[23:0], r_key[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[8*g +: 8]),
                .o_byte (w_sub[8*g +: 8])
            );
        end
    endgenerate

    assign w_temp      = w_sub ^ {r_rcon, 24'h0};
    assign w_w0        = r_key[127:96] ^ w_temp;
    assign w_w1        = r_key[95:64] ^ w_w0;
    assign w_w2        = r_key[63:32] ^ w_w1;
    assign w_w3        = r_key[31:0] ^ w_w2;
    assign w_next_key  = {w_w0, w_w1, w_w2, w_w3};
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    assign w_last      = (r_cnt == 4'(NR));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        unique case (r_state)
            IDLE, READY: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = EXPAND;
                end
            end
            EXPAND: begin
                w_step = 1'b1;
                if (w_last) w_state_next = READY;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_key       <= '0;
            r_cnt       <= '0;
            r_rcon      <= 8'h01;
            r_busy      <= 1'b0;
            r_key_ready <= 1'b0;
        end else if (w_load) begin
            r_key       <= key_in;
            r_cnt       <= 4'd1;
            r_rcon      <= 8'h01;
            r_busy      <= 1'b1;
            r_key_ready <= 1'b0;
        end else if (w_step) begin
            r_key  <= w_next_key;
            r_cnt  <= r_cnt + 4'd1;
            r_rcon <= w_rcon_next;
            if (w_last) begin
                r_busy      <= 1'b0;
                r_key_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= NR; i++) r_bank[i] <= '0;
        end else if (w_load) begin
            r_bank[0] <= key_in;
        end else if (w_step) begin
            r_bank[r_cnt] <= w_next_key;
        end
    end

    // Read sees the pre-edge bank contents; no write-through bypass.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                     r_round_key <= '0;
        else if (round_idx <= 4'(NR))  r_round_key <= r_bank[round_idx];
        else                           r_round_key <= '0;
    end

    assign round_key = r_round_key;
    assign busy      = r_busy;
    assign key_ready = r_key_ready;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key schedule vectors.

module tb_aes_key_expander;

    localparam logic [127:0] K_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K_A2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K_A9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] K_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K_B   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K_B1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K_B10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clock;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic [3:0]   round_idx;
    logic [127:0] round_key;
    logic         busy;
    logic         key_ready;

    int checks;
    int failures;

    aes_key_expander dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .key_in    (key_in),
        .round_idx (round_idx),
        .round_key (round_key),
        .busy      (busy),
        .key_ready (key_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [127:0] k);
        @(negedge clock);
        key_in = k;
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Returns edges until key_ready and number of busy samples seen.
    task automatic wait_ready(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (!key_ready && n < 30) begin
            if (busy) nb++;
            @(posedge clock);
            #1 n++;
        end
    endtask

    task automatic rd(input logic [3:0] idx, output logic [127:0] v);
        @(negedge clock);
        round_idx = idx;
        @(posedge clock);
        #1 v = round_key;
    endtask

    logic [127:0] v;
    int           n;
    int           nb;

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        key_in    = '0;
        round_idx = '0;
        #12;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_rdy", 128'(key_ready), 128'd0);
        chk("rst_rk", round_key, '0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            rd(4'(i), v);
            chk($sformatf("rst_bank%0d", i), v, '0);
        end

        // FIPS-197 Appendix A key
        pulse_start(K_A);
        chk("a_busy0", 128'(busy), 128'd1);
        wait_ready(n, nb);
        chk("a_lat", 128'(n), 128'd10);
        chk("a_busycnt", 128'(nb), 128'd10);
        chk("a_busy_end", 128'(busy), 128'd0);
        rd(4'd1, v);  chk("a_idx1", v, K_A1);
        rd(4'd2, v);  chk("a_idx2", v, K_A2);
        rd(4'd9, v);  chk("a_idx9", v, K_A9);
        rd(4'd10, v); chk("a_idx10", v, K_A10);
        rd(4'd0, v);  chk("a_idx0", v, K_A);
        rd(4'd11, v); chk("a_idx11", v, '0);
        rd(4'd15, v); chk("a_idx15", v, '0);

        // READY restart with key B, plus one-cycle read latency
        rd(4'd0, v);
        pulse_start(K_B);
        chk("b_rdy_drop", 128'(key_ready), 128'd0);
        chk("b_busy", 128'(busy), 128'd1);
        wait_ready(n, nb);
        chk("b_lat", 128'(n), 128'd10);
        rd(4'd0, v);  chk("b_idx0", v, K_B);
        rd(4'd1, v);  chk("b_idx1", v, K_B1);
        @(negedge clock);
        round_idx = 4'd10;
        #1 chk("b_lat_hold", round_key, K_B1);
        @(posedge clock);
        #1 chk("b_idx10", round_key, K_B10);

        // start re-pulsed 3 cycles into EXPAND is ignored
        pulse_start(K_A);
        repeat (2) @(posedge clock);
        @(negedge clock);
        key_in = K_B;
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_ready(n, nb);
        chk("rp_lat", 128'(n), 128'd7);
        rd(4'd1, v);  chk("rp_idx1", v, K_A1);
        rd(4'd10, v); chk("rp_idx10", v, K_A10);

        // Reset during EXPAND
        pulse_start(K_B);
        repeat (4) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mr_busy", 128'(busy), 128'd0);
        chk("mr_rdy", 128'(key_ready), 128'd0);
        chk("mr_rk", round_key, '0);
        @(negedge clock);
        reset = 1'b0;
        rd(4'd0, v);  chk("mr_idx0", v, '0);
        rd(4'd1, v);  chk("mr_idx1", v, '0);
        rd(4'd10, v); chk("mr_idx10", v, '0);
        pulse_start(K_A);
        wait_ready(n, nb);
        chk("post_lat", 128'(n), 128'd10);
        rd(4'd10, v); chk("post_idx10", v, K_A10);
        rd(4'd1, v);  chk("post_idx1", v, K_A1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
